msf_frame_decoder: RTL and testbench

Upstream neighbour of the calendar/time counter bank. Consumes per-second MSF symbols (A/B bits plus minute-marker strobe) from the pulse classifier and assembles one 60-second frame. Checks the frame's structure, parity and BCD ranges. On each good frame it emits a one-cycle load strobe with BCD date/time fields, at the widths the counter bank's load inputs take.

---
 rtl/msf_pkg.sv | 74 +++++++
 rtl/msf_frame_check.sv | 88 ++++++++
 rtl/msf_frame_decoder.sv | 154 +++++++++++++++
 tb/tb_msf_frame_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msf_pkg.sv
// Shared MSF frame definitions: FSM states, frame bit positions, time payload.
package msf_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_e;

  // Seconds per frame (excluding the second-0 marker) and bit counter sizing.
  localparam int unsigned FRAME_BITS = 59;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned CNT_MAX    = 63;

  // A-bit field positions, MSB first.
  localparam int unsigned YEAR_MSB   = 17;
  localparam int unsigned YEAR_LSB   = 24;
  localparam int unsigned MONTH_MSB  = 25;
  localparam int unsigned MONTH_LSB  = 29;
  localparam int unsigned DAY_MSB    = 30;
  localparam int unsigned DAY_LSB    = 35;
  localparam int unsigned DOW_MSB    = 36;
  localparam int unsigned DOW_LSB    = 38;
  localparam int unsigned HOUR_MSB   = 39;
  localparam int unsigned HOUR_LSB   = 44;
  localparam int unsigned MIN_MSB    = 45;
  localparam int unsigned MIN_LSB    = 51;
  localparam int unsigned MARKER_MSB = 52;
  localparam int unsigned MARKER_LSB = 59;

  // B-bit parity positions.
  localparam int unsigned PAR_YEAR   = 54;
  localparam int unsigned PAR_DATE   = 55;
  localparam int unsigned PAR_DOW    = 56;
  localparam int unsigned PAR_HM     = 57;

  localparam logic [7:0] MARKER_PATTERN = 8'b0111_1110;

  // BCD date/time payload handed to the counter bank.
  typedef struct packed {
    logic [3:0] year_h;
    logic [3:0] year_l;
    logic       month_h;
    logic [3:0] month_l;
    logic [1:0] day_h;
    logic [3:0] day_l;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
  } msf_time_t;

  // 00-01-01 00:00
  localparam msf_time_t TIME_RESET = '{
    year_h:   4'd0, year_l:   4'd0,
    month_h:  1'b0, month_l:  4'd1,
    day_h:    2'd0, day_l:    4'd1,
    hour_h:   2'd0, hour_l:   4'd0,
    minute_h: 3'd0, minute_l: 4'd0
  };

  // XOR of A bits lo..hi inclusive.
  function automatic logic xor_range(input logic [59:1] v,
                                     input int unsigned lo,
                                     input int unsigned hi);
    logic r;
    r = 1'b0;
    for (int i = 1; i <= 59; i++) begin
      if (i >= int'(lo) && i <= int'(hi)) r = r ^ v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/msf_frame_check.sv
// Combinational frame validator and BCD field extractor.
//   a_i      : A bits of seconds 1..59
//   b_i      : B bits of seconds 54..57 (parity)
//   count_i  : number of symbols received in the frame
//   good_c   : frame passes all enabled checks
//   fields_c : extracted BCD date/time
module msf_frame_check
  import msf_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1,
  parameter bit CHECK_MARKER = 1'b1
) (
  input  logic [59:1]      a_i,
  input  logic [57:54]     b_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             good_c,
  output msf_time_t        fields_c
);

  logic       len_ok;
  logic       marker_ok;
  logic       parity_ok;
  logic       nibble_ok;
  logic       range_ok;
  logic [7:0] marker_bits;
  logic       unused_a;

  // Seconds 1..16 carry DUT1/unused data not needed here.
  assign unused_a = ^a_i[16:1];

  // Field extraction, transmitted MSB first.
  always_comb begin
    fields_c          = TIME_RESET;
    fields_c.year_h   = {a_i[YEAR_MSB],   a_i[YEAR_MSB+1], a_i[YEAR_MSB+2], a_i[YEAR_MSB+3]};
    fields_c.year_l   = {a_i[YEAR_MSB+4], a_i[YEAR_MSB+5], a_i[YEAR_MSB+6], a_i[YEAR_LSB]};
    fields_c.month_h  = a_i[MONTH_MSB];
    fields_c.month_l  = {a_i[MONTH_MSB+1], a_i[MONTH_MSB+2], a_i[MONTH_MSB+3], a_i[MONTH_LSB]};
    fields_c.day_h    = {a_i[DAY_MSB], a_i[DAY_MSB+1]};
    fields_c.day_l    = {a_i[DAY_MSB+2], a_i[DAY_MSB+3], a_i[DAY_MSB+4], a_i[DAY_LSB]};
    fields_c.hour_h   = {a_i[HOUR_MSB], a_i[HOUR_MSB+1]};
    fields_c.hour_l   = {a_i[HOUR_MSB+2], a_i[HOUR_MSB+3], a_i[HOUR_MSB+4], a_i[HOUR_LSB]};
    fields_c.minute_h = {a_i[MIN_MSB], a_i[MIN_MSB+1], a_i[MIN_MSB+2]};
    fields_c.minute_l = {a_i[MIN_MSB+3], a_i[MIN_MSB+4], a_i[MIN_MSB+5], a_i[MIN_LSB]};
  end

  // Marker bits 52..59, first-received bit as MSB.
  always_comb begin
    marker_bits = '0;
    for (int i = 0; i < 8; i++) begin
      marker_bits[7-i] = a_i[MARKER_MSB+i];
    end
  end

  assign len_ok    = (count_i == CNT_W'(FRAME_BITS));
  assign marker_ok = (marker_bits == MARKER_PATTERN);

  // Each group plus its B bit must hold an odd number of ones.
  assign parity_ok = (xor_range(a_i, YEAR_MSB, YEAR_LSB) ^ b_i[PAR_YEAR]) &&
                     (xor_range(a_i, MONTH_MSB, DAY_LSB) ^ b_i[PAR_DATE]) &&
                     (xor_range(a_i, DOW_MSB, DOW_LSB)   ^ b_i[PAR_DOW])  &&
                     (xor_range(a_i, HOUR_MSB, MIN_LSB)  ^ b_i[PAR_HM]);

  assign nibble_ok = (fields_c.year_h  <= 4'd9) && (fields_c.year_l   <= 4'd9) &&
                     (fields_c.month_l <= 4'd9) && (fields_c.day_l    <= 4'd9) &&
                     (fields_c.hour_l  <= 4'd9) && (fields_c.minute_l <= 4'd9);

  // Decimal ranges evaluated directly on the BCD digits.
  always_comb begin
    logic month_ok;
    logic day_ok;
    logic hour_ok;
    logic minute_ok;
    month_ok  = fields_c.month_h ? (fields_c.month_l <= 4'd2) : (fields_c.month_l != 4'd0);
    day_ok    = 1'b1;
    if (fields_c.day_h == 2'd0)      day_ok = (fields_c.day_l != 4'd0);
    else if (fields_c.day_h == 2'd3) day_ok = (fields_c.day_l <= 4'd1);
    hour_ok   = (fields_c.hour_h <= 2'd1) ||
                ((fields_c.hour_h == 2'd2) && (fields_c.hour_l <= 4'd3));
    minute_ok = (fields_c.minute_h <= 3'd5);
    range_ok  = month_ok && day_ok && hour_ok && minute_ok;
  end

  assign good_c = len_ok &&
                  (!CHECK_MARKER || marker_ok) &&
                  (!CHECK_PARITY || parity_ok) &&
                  nibble_ok && range_ok;

endmodule

// File: rtl/msf_frame_decoder.sv
// Assembles MSF per-second symbols into a 60 s frame and emits verified BCD time.
//   clk_i, rst_ni        : clock, async active-low reset
//   bit_valid_i/a/b      : symbol strobe and A/B bits for seconds 1..59
//   minute_mark_i        : second-0 marker strobe
//   load_o               : one-cycle strobe, fields hold a verified frame
//   *_h_o / *_l_o        : BCD year, month, day, hour, minute, second (second tied 0)
//   synced_o             : a marker has been seen since reset
//   frame_err_o          : one-cycle strobe, frame rejected
module msf_frame_decoder
  import msf_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1,
  parameter bit CHECK_MARKER = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_valid_i,
  input  logic       bit_a_i,
  input  logic       bit_b_i,
  input  logic       minute_mark_i,
  output logic       load_o,
  output logic [3:0] year_h_o,
  output logic [3:0] year_l_o,
  output logic       month_h_o,
  output logic [3:0] month_l_o,
  output logic [1:0] day_h_o,
  output logic [3:0] day_l_o,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] minute_h_o,
  output logic [3:0] minute_l_o,
  output logic [2:0] second_h_o,
  output logic [3:0] second_l_o,
  output logic       synced_o,
  output logic       frame_err_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [59:1]      a_q, a_d;
  logic [57:54]     b_q, b_d;
  logic             synced_q, synced_d;
  logic             load_q, load_d;
  logic             frame_err_q, frame_err_d;
  msf_time_t        fields_q, fields_d;

  logic             good_c;
  msf_time_t        fields_c;

  msf_frame_check #(
    .CHECK_PARITY (CHECK_PARITY),
    .CHECK_MARKER (CHECK_MARKER)
  ) u_check (
    .a_i      (a_q),
    .b_i      (b_q),
    .count_i  (count_q),
    .good_c   (good_c),
    .fields_c (fields_c)
  );

  // State and frame storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HUNT;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      synced_q    <= 1'b0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      fields_q    <= TIME_RESET;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      synced_q    <= synced_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      fields_q    <= fields_d;
    end
  end

  // Next-state, symbol capture and result strobes.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    synced_d    = synced_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
    fields_d    = fields_q;

    unique case (state_q)
      HUNT: begin
        if (minute_mark_i) begin
          state_d  = COLLECT;
          count_d  = '0;
          a_d      = '0;
          b_d      = '0;
          synced_d = 1'b1;
        end
      end

      COLLECT: begin
        // Marker takes priority over a coincident symbol.
        if (minute_mark_i) begin
          state_d = CHECK;
        end else if (bit_valid_i) begin
          // Symbol for second count+1; symbols past 59 only bump the count.
          for (int i = 1; i <= 59; i++) begin
            if (count_q == CNT_W'(i - 1)) a_d[i] = bit_a_i;
          end
          for (int i = 54; i <= 57; i++) begin
            if (count_q == CNT_W'(i - 1)) b_d[i] = bit_b_i;
          end
          if (count_q != CNT_W'(CNT_MAX)) count_d = count_q + CNT_W'(1);
        end
      end

      CHECK: begin
        state_d     = COLLECT;
        count_d     = '0;
        a_d         = '0;
        b_d         = '0;
        load_d      = good_c;
        frame_err_d = !good_c;
        if (good_c) fields_d = fields_c;
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  assign load_o      = load_q;
  assign frame_err_o = frame_err_q;
  assign synced_o    = synced_q;
  assign year_h_o    = fields_q.year_h;
  assign year_l_o    = fields_q.year_l;
  assign month_h_o   = fields_q.month_h;
  assign month_l_o   = fields_q.month_l;
  assign day_h_o     = fields_q.day_h;
  assign day_l_o     = fields_q.day_l;
  assign hour_h_o    = fields_q.hour_h;
  assign hour_l_o    = fields_q.hour_l;
  assign minute_h_o  = fields_q.minute_h;
  assign minute_l_o  = fields_q.minute_l;
  assign second_h_o  = 3'd0;
  assign second_l_o  = 4'd0;

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Bench for msf_frame_decoder: parity-checking and parity-ignoring instances
// share one stimulus stream; expectations come from a decimal frame model.
module tb_msf_frame_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic bit_valid, bit_a, bit_b, minute_mark;

  logic       load   [2];
  logic       err    [2];
  logic       synced [2];
  logic [3:0] yh [2];
  logic [3:0] yl [2];
  logic       mh [2];
  logic [3:0] ml [2];
  logic [1:0] dh [2];
  logic [3:0] dl [2];
  logic [1:0] hh [2];
  logic [3:0] hl [2];
  logic [2:0] nh [2];
  logic [3:0] nl [2];
  logic [2:0] sh [2];
  logic [3:0] sl [2];

  int n_tests = 0;
  int n_fail  = 0;

  bit          fa [64];
  bit          fb [64];
  logic [38:0] exp_f [2];
  logic [38:0] reset_f;

  always #5 clk = ~clk;

  msf_frame_decoder #(.CHECK_PARITY(1'b1), .CHECK_MARKER(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bit_valid_i(bit_valid), .bit_a_i(bit_a),
    .bit_b_i(bit_b), .minute_mark_i(minute_mark), .load_o(load[0]),
    .year_h_o(yh[0]), .year_l_o(yl[0]), .month_h_o(mh[0]), .month_l_o(ml[0]),
    .day_h_o(dh[0]), .day_l_o(dl[0]), .hour_h_o(hh[0]), .hour_l_o(hl[0]),
    .minute_h_o(nh[0]), .minute_l_o(nl[0]), .second_h_o(sh[0]), .second_l_o(sl[0]),
    .synced_o(synced[0]), .frame_err_o(err[0]));

  msf_frame_decoder #(.CHECK_PARITY(1'b0), .CHECK_MARKER(1'b1)) u_dut_np (
    .clk_i(clk), .rst_ni(rst_n), .bit_valid_i(bit_valid), .bit_a_i(bit_a),
    .bit_b_i(bit_b), .minute_mark_i(minute_mark), .load_o(load[1]),
    .year_h_o(yh[1]), .year_l_o(yl[1]), .month_h_o(mh[1]), .month_l_o(ml[1]),
    .day_h_o(dh[1]), .day_l_o(dl[1]), .hour_h_o(hh[1]), .hour_l_o(hl[1]),
    .minute_h_o(nh[1]), .minute_l_o(nl[1]), .second_h_o(sh[1]), .second_l_o(sl[1]),
    .synced_o(synced[1]), .frame_err_o(err[1]));

  function automatic logic [38:0] mk_fields(int y1, int y0, int m1, int m0, int d1,
                                            int d0, int h1, int h0, int n1, int n0);
    return {4'(y1), 4'(y0), 1'(m1), 4'(m0), 2'(d1), 4'(d0),
            2'(h1), 4'(h0), 3'(n1), 4'(n0), 3'd0, 4'd0};
  endfunction

  function automatic logic [38:0] got_fields(int k);
    return {yh[k], yl[k], mh[k], ml[k], dh[k], dl[k],
            hh[k], hl[k], nh[k], nl[k], sh[k], sl[k]};
  endfunction

  // Unsigned value of len A bits starting at second msb, MSB first.
  function automatic int val(int msb, int len);
    int v = 0;
    for (int j = 0; j < len; j++) v = v * 2 + int'(fa[msb + j]);
    return v;
  endfunction

  function automatic int ones(int lo, int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(fa[i]);
    return c;
  endfunction

  function automatic void put(int msb, int len, int v);
    for (int j = 0; j < len; j++) fa[msb + j] = 1'((v >> (len - 1 - j)) & 1);
  endfunction

  // Decimal reference decode of the frame in fa/fb.
  function automatic void model_eval(input int nbits, input bit cp,
                                     output bit good, output logic [38:0] f);
    int pat [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int y1 = val(17, 4), y0 = val(21, 4);
    int m1 = val(25, 1), m0 = val(26, 4);
    int d1 = val(30, 2), d0 = val(32, 4);
    int h1 = val(39, 2), h0 = val(41, 4);
    int n1 = val(45, 3), n0 = val(48, 4);
    int month = 10 * m1 + m0, day = 10 * d1 + d0;
    int hour = 10 * h1 + h0, minute = 10 * n1 + n0;
    good = (nbits == 59);
    for (int i = 0; i < 8; i++) if (int'(fa[52 + i]) != pat[i]) good = 1'b0;
    if (cp) begin
      if ((ones(17, 24) + int'(fb[54])) % 2 == 0) good = 1'b0;
      if ((ones(25, 35) + int'(fb[55])) % 2 == 0) good = 1'b0;
      if ((ones(36, 38) + int'(fb[56])) % 2 == 0) good = 1'b0;
      if ((ones(39, 51) + int'(fb[57])) % 2 == 0) good = 1'b0;
    end
    if (y1 > 9 || y0 > 9 || m0 > 9 || d0 > 9 || h0 > 9 || n0 > 9) good = 1'b0;
    if (month < 1 || month > 12 || day < 1 || day > 31) good = 1'b0;
    if (hour > 23 || minute > 59) good = 1'b0;
    f = mk_fields(y1, y0, m1, m0, d1, d0, h1, h0, n1, n0);
  endfunction

  // Frame with given BCD digits, correct marker and odd parity; filler random.
  task automatic build_frame(int y1, int y0, int m1, int m0, int d1, int d0,
                             int dow, int h1, int h0, int n1, int n0);
    for (int i = 0; i < 64; i++) begin
      fa[i] = 1'($urandom);
      fb[i] = 1'($urandom);
    end
    put(17, 4, y1); put(21, 4, y0);
    put(25, 1, m1); put(26, 4, m0);
    put(30, 2, d1); put(32, 4, d0);
    put(36, 3, dow);
    put(39, 2, h1); put(41, 4, h0);
    put(45, 3, n1); put(48, 4, n0);
    put(52, 8, 8'h7E);
    fb[54] = (ones(17, 24) % 2 == 0);
    fb[55] = (ones(25, 35) % 2 == 0);
    fb[56] = (ones(36, 38) % 2 == 0);
    fb[57] = (ones(39, 51) % 2 == 0);
  endtask

  task automatic build_ref_frame();
    build_frame(2, 3, 0, 3, 1, 4, 2, 1, 5, 2, 7);
    fb[54] = 1'b0; fb[55] = 1'b1; fb[56] = 1'b0; fb[57] = 1'b0;
  endtask

  task automatic check_quiet(string name);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (load[k] !== 1'b0 || err[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d: load=%b err=%b, expected 0 0", name, k, load[k], err[k]);
      end
    end
  endtask

  // Send n symbols, each preceded by 0..max_gap idle cycles.
  task automatic drive_bits(int n, int max_gap);
    for (int i = 1; i <= n; i++) begin
      int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        check_quiet("quiet_gap");
        bit_valid = 1'b0;
      end
      @(negedge clk);
      check_quiet("quiet_bit");
      bit_valid = 1'b1;
      bit_a = fa[i];
      bit_b = fb[i];
    end
    @(negedge clk);
    check_quiet("quiet_end");
    bit_valid = 1'b0;
  endtask

  // Marker and result check; first=1 means the decoder was hunting.
  task automatic send_marker(int nbits, bit first, bit with_bit);
    bit          g;
    logic [38:0] f;
    @(negedge clk);
    check_quiet("pre_mark");
    minute_mark = 1'b1;
    bit_valid   = with_bit;
    bit_a       = 1'($urandom);
    bit_b       = 1'($urandom);
    @(negedge clk);
    check_quiet("check_cycle");
    minute_mark = 1'b0;
    bit_valid   = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit el, ee;
      if (first) begin
        el = 1'b0; ee = 1'b0;
      end else begin
        model_eval(nbits, (k == 0), g, f);
        el = g; ee = !g;
        if (g) exp_f[k] = f;
      end
      n_tests++;
      if (load[k] !== el || err[k] !== ee) begin
        n_fail++;
        $display("FAIL strobe dut%0d nbits=%0d: load=%b err=%b, expected %b %b",
                 k, nbits, load[k], err[k], el, ee);
      end
      n_tests++;
      if (got_fields(k) !== exp_f[k]) begin
        n_fail++;
        $display("FAIL fields dut%0d: got %h, expected %h", k, got_fields(k), exp_f[k]);
      end
      n_tests++;
      if (synced[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL synced dut%0d: got %b, expected 1", k, synced[k]);
      end
    end
  endtask

  task automatic check_reset_outputs(string name);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (load[k] !== 1'b0 || err[k] !== 1'b0 || synced[k] !== 1'b0 ||
          got_fields(k) !== reset_f) begin
        n_fail++;
        $display("FAIL %s dut%0d: load=%b err=%b synced=%b fields=%h, expected 0 0 0 %h",
                 name, k, load[k], err[k], synced[k], got_fields(k), reset_f);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bit_valid = 1'b0; bit_a = 1'b0; bit_b = 1'b0; minute_mark = 1'b0;
    reset_f  = mk_fields(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    exp_f[0] = reset_f;
    exp_f[1] = reset_f;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_hunt();
    build_ref_frame();
    drive_bits(20, 1);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (synced[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL hunt_synced dut%0d: got %b, expected 0", k, synced[k]);
      end
    end
    send_marker(0, 1'b1, 1'b0);
  endtask

  task automatic test_good();
    build_ref_frame();
    drive_bits(59, 2);
    send_marker(59, 1'b0, 1'b0);
    n_tests++;
    if (got_fields(0) !== mk_fields(2, 3, 0, 3, 1, 4, 1, 5, 2, 7)) begin
      n_fail++;
      $display("FAIL ref_fields: got %h, expected %h", got_fields(0),
               mk_fields(2, 3, 0, 3, 1, 4, 1, 5, 2, 7));
    end
  endtask

  task automatic test_parity();
    build_frame(9, 8, 1, 1, 2, 9, 5, 0, 7, 4, 1);
    fb[57] = !fb[57];
    drive_bits(59, 1);
    send_marker(59, 1'b0, 1'b0);
  endtask

  task automatic test_length();
    build_ref_frame();
    drive_bits(58, 1);
    send_marker(58, 1'b0, 1'b0);
    build_ref_frame();
    drive_bits(60, 1);
    send_marker(60, 1'b0, 1'b0);
    build_frame(0, 5, 0, 6, 3, 0, 3, 2, 3, 5, 9);
    drive_bits(59, 1);
    send_marker(59, 1'b0, 1'b0);
  endtask

  task automatic test_range();
    build_frame(2, 3, 1, 3, 1, 4, 2, 1, 5, 2, 7);
    drive_bits(59, 1);
    send_marker(59, 1'b0, 1'b0);
    build_frame(2, 3, 0, 3, 1, 4, 2, 1, 5, 2, 10);
    drive_bits(59, 1);
    send_marker(59, 1'b0, 1'b0);
  endtask

  // No idle cycles; second frame's marker coincides with a stray symbol.
  task automatic test_back_to_back();
    build_frame(1, 2, 1, 2, 3, 1, 7, 2, 3, 5, 9);
    drive_bits(59, 0);
    send_marker(59, 1'b0, 1'b0);
    build_frame(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    drive_bits(59, 0);
    send_marker(59, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int y = int'($urandom_range(99, 0)), mo = int'($urandom_range(12, 1));
      int d = int'($urandom_range(31, 1)), h = int'($urandom_range(23, 0));
      int mi = int'($urandom_range(59, 0));
      int n = 59;
      int r = int'($urandom_range(15, 0));
      build_frame(y / 10, y % 10, mo / 10, mo % 10, d / 10, d % 10,
                  int'($urandom_range(7, 1)), h / 10, h % 10, mi / 10, mi % 10);
      if (r == 0) put(21, 4, int'($urandom_range(15, 0)));
      if (r == 1) put(30, 2, int'($urandom_range(3, 0)));
      if (r == 2) put(39, 2, int'($urandom_range(3, 0)));
      if (r == 3) put(45, 3, int'($urandom_range(7, 0)));
      if (r == 4) fa[52 + int'($urandom_range(7, 0))] ^= 1'b1;
      if (r == 5 || r == 6) fb[54 + int'($urandom_range(3, 0))] ^= 1'b1;
      if (r == 7) n = int'($urandom_range(61, 57));
      drive_bits(n, 2);
      send_marker(n, 1'b0, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    build_ref_frame();
    drive_bits(30, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    exp_f[0] = reset_f;
    exp_f[1] = reset_f;
    @(negedge clk);
    rst_n = 1'b1;
    send_marker(0, 1'b1, 1'b0);
    build_ref_frame();
    drive_bits(59, 1);
    send_marker(59, 1'b0, 1'b0);
    @(negedge clk);
    check_quiet("post_load");
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_good();
    test_parity();
    test_length();
    test_range();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
